// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: issues one request per load/store to a
// variable-latency data memory, stalls the front end until it answers, and feeds MEM/WB.
module mem_access_ctrl #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_memread,
  input  logic              ex_memwrite,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_wdata,
  output logic              stall,
  output logic              wb_bubble,
  output logic [DATA_W-1:0] mem_rdata_out,
  output logic              dm_enable,
  output logic              dm_wr,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata,
  input  logic              dm_valid,
  output logic              err,
  output logic [1:0]        state_dbg
);

  // Memory handshake: dm_enable is a single-cycle request pulse carrying dm_wr/dm_addr/
  // dm_wdata; the memory answers with one dm_valid cycle (read data or write ack) at any
  // later point, including the pulse cycle itself. dm_valid outside BUSY is ignored.

  localparam int WCW = $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [WCW-1:0] wait_cnt;
  logic           req;
  logic           timeout;

  assign req       = ex_memread | ex_memwrite;
  assign timeout   = (state == BUSY) && !dm_valid && (wait_cnt == WAIT_LAST);
  assign state_dbg = state;
  assign wb_bubble = stall;

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          stall      = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (dm_valid || timeout) state_next = DONE;
      end
      // The finished instruction leaves EX/MEM this edge; its request is still
      // visible here and must not start a second access.
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (rst) stall = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      dm_enable     <= 1'b0;
      dm_wr         <= 1'b0;
      dm_addr       <= '0;
      dm_wdata      <= '0;
      mem_rdata_out <= '0;
      err           <= 1'b0;
      wait_cnt      <= '0;
    end else begin
      state     <= state_next;
      dm_enable <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            dm_addr   <= ex_addr;
            dm_wdata  <= ex_wdata;
            dm_wr     <= ex_memwrite;
            dm_enable <= 1'b1;
            wait_cnt  <= '0;
          end
        end
        BUSY: begin
          if (dm_valid) begin
            if (!dm_wr) mem_rdata_out <= dm_rdata;
          end else if (timeout) begin
            err           <= 1'b1;
            mem_rdata_out <= {DATA_W{1'b1}};
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
